// File: rtl/clock.sv
// rtl/clock.sv - countdown tick prescaler and registered next remaining-time selector
// The parent feeds next_time back as cur_time; this block only decides the following value.
module clock #(
   parameter int TICK_DIV = 100_000_000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic [6:0] cur_time,
   output logic [6:0] next_time,
   input  logic       pause,
   input  logic       restart,
   input  logic       off
);

   localparam int          PW   = $clog2(TICK_DIV);
   localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

   logic [PW-1:0] prescale;
   logic          tick;
   logic [6:0]    time_sel;

   assign tick = (prescale == LAST) && !pause && !off && !restart;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         prescale <= '0;
      end else if (restart || off) begin
         prescale <= '0;
      end else if (!pause) begin
         prescale <= (prescale == LAST) ? '0 : prescale + PW'(1);
      end
   end

   // Decrement saturates at zero; off dominates everything else.
   always_comb begin
      time_sel = cur_time;
      if (off) begin
         time_sel = 7'd0;
      end else if (tick && (cur_time != 7'd0)) begin
         time_sel = cur_time - 7'd1;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         next_time <= 7'd0;
      end else begin
         next_time <= time_sel;
      end
   end

endmodule

// File: tb/tb_clock.sv
// tb/tb_clock.sv - scoreboard bench for clock with a cycle-count reference model
module tb_clock;

   localparam int TD = 4;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic [6:0] cur_time = 7'd0;
   logic [6:0] next_time;
   logic       pause = 1'b0;
   logic       restart = 1'b0;
   logic       off = 1'b0;

   clock #(.TICK_DIV(TD)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .cur_time  (cur_time),
      .next_time (next_time),
      .pause     (pause),
      .restart   (restart),
      .off       (off)
   );

   always #5 clk = ~clk;

   int         n_pass = 0;
   int         n_total = 0;
   logic [6:0] exp_q[$];
   int         active = 0;      // unpaused cycles since reset/restart/off
   int         model_time = 0;

   task automatic check(input string name, input logic [6:0] act, input logic [6:0] exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // Drive one cycle of inputs at the falling edge and queue what the next rising edge must yield.
   task automatic step(input bit p, input bit r, input bit o, input bit ld, input int val);
      int cur;
      int e;
      @(negedge clk);
      pause   = p;
      restart = r;
      off     = o;
      cur     = ld ? val : model_time;
      cur_time = 7'(cur);
      if (o) begin
         e = 0;
         active = 0;
      end else if (r) begin
         e = cur;
         active = 0;
      end else if (p) begin
         e = cur;
      end else begin
         e = ((active % TD) == TD - 1) ? ((cur > 0) ? cur - 1 : 0) : cur;
         active++;
      end
      exp_q.push_back(7'(e));
      model_time = e;
   endtask

   task automatic run(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0);
   endtask

   task automatic reset_pulse();
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1 check("async_reset", next_time, 7'd0);
      #1 rst_n = 1'b1;
      active = 0;
      model_time = 0;
   endtask

   always begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) check("scoreboard", next_time, exp_q.pop_front());
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      repeat (2) @(posedge clk);
      #2 check("reset_state", next_time, 7'd0);
      rst_n = 1'b1;

      // load 10, count down to zero after 40 cycles, then hold at zero
      step(0, 0, 0, 1, 10);
      run(39);
      @(posedge clk);
      #2 check("reach_zero", next_time, 7'd0);
      run(8);
      @(posedge clk);
      #2 check("no_wrap", next_time, 7'd0);

      // pause across the tick phase at 5
      step(0, 0, 0, 1, 5);
      while ((active % TD) != TD - 1) step(0, 0, 0, 0, 0);
      for (int i = 0; i < 10; i++) step(1, 0, 0, 0, 0);
      run(6);

      // off while counting at 7, then reload 10
      step(0, 0, 0, 1, 7);
      run(2);
      step(0, 0, 1, 0, 0);
      step(0, 0, 0, 1, 10);
      run(6);

      // async reset while holding 12
      step(0, 0, 0, 1, 12);
      run(2);
      reset_pulse();
      step(0, 0, 0, 1, 12);
      run(6);

      // restart one cycle before a tick at 20
      step(0, 0, 0, 1, 20);
      while ((active % TD) != TD - 2) step(0, 0, 0, 0, 0);
      step(0, 1, 0, 0, 0);
      run(6);

      // high values decrement like any other
      step(0, 0, 0, 1, 127);
      run(9);

      for (int i = 0; i < 400; i++) begin
         int rp;
         rp = $urandom_range(0, 99);
         if (rp < 2) begin
            reset_pulse();
         end else begin
            step(rp < 22, ($urandom_range(0, 99) < 5), ($urandom_range(0, 99) < 3),
                 ($urandom_range(0, 99) < 6), $urandom_range(0, 127));
         end
      end

      repeat (2) @(posedge clk);
      #2;
      n_total++;
      if (exp_q.size() == 0) n_pass++;
      else $display("FAIL queue_drain: got %0d pending expected 0", exp_q.size());

      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
